// File: rtl/mux_wb_reg_if.sv
// Bus bundle for the write-back source selector: request/select/operands in,
// registered write-back data, stall and external-FIFO status out.
//
// Handshake: REQ is accepted on any rising edge where BUSY is low; the
// result appears with a one-cycle DATO_VAL pulse after that edge. While
// BUSY is high, REQ/SELEC are ignored. DATO_IN_VAL is a push strobe with
// no back-pressure; pushes into a full FIFO are dropped and flagged in EXT_OVF.
interface mux_wb_reg_if #(
  parameter int WIDTH    = 8,
  parameter int REG_BITS = 3
);
  logic                REQ;
  logic [2:0]          SELEC;
  logic [REG_BITS-1:0] RY;
  logic [WIDTH-1:0]    RY_DATO;
  logic [WIDTH-1:0]    IMM;
  logic [WIDTH-1:0]    DATO_IN;
  logic                DATO_IN_VAL;
  logic                OVF_CLR;
  logic [WIDTH-1:0]    DATO;
  logic                DATO_VAL;
  logic                BUSY;
  logic                EXT_EMPTY;
  logic                EXT_FULL;
  logic                EXT_OVF;
  logic                STATE_DBG;

  modport master (
    output REQ, SELEC, RY, RY_DATO, IMM, DATO_IN, DATO_IN_VAL, OVF_CLR,
    input  DATO, DATO_VAL, BUSY, EXT_EMPTY, EXT_FULL, EXT_OVF, STATE_DBG
  );

  modport slave (
    input  REQ, SELEC, RY, RY_DATO, IMM, DATO_IN, DATO_IN_VAL, OVF_CLR,
    output DATO, DATO_VAL, BUSY, EXT_EMPTY, EXT_FULL, EXT_OVF, STATE_DBG
  );
endinterface

// File: rtl/mux_wb_reg.sv
// Registered write-back source selector with a small external-input FIFO.
// Stalls (BUSY) when the FIFO head is requested but no byte has arrived yet.
module mux_wb_reg #(
  parameter int WIDTH     = 8,
  parameter int REG_BITS  = 3,
  parameter int EXT_DEPTH = 4
) (
  input logic          CLK,
  input logic          RST_N,
  mux_wb_reg_if.slave  bus
);

  localparam int PTR_W = $clog2(EXT_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(EXT_DEPTH);

  localparam logic [2:0] SEL_RY  = 3'b001;
  localparam logic [2:0] SEL_RYD = 3'b010;
  localparam logic [2:0] SEL_EXT = 3'b011;
  localparam logic [2:0] SEL_IMM = 3'b100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] mem_q [EXT_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] dato_q, dato_d;
  logic             dato_val_q, dato_val_d;

  logic             pop;
  logic             push_ok;
  logic             ovf_set;
  logic [WIDTH-1:0] ry_ext;
  logic [WIDTH-1:0] head;

  assign head = mem_q[rd_ptr_q];

  // Slice assignment keeps this legal when REG_BITS == WIDTH.
  always_comb begin
    ry_ext                 = '0;
    ry_ext[REG_BITS-1:0]   = bus.RY;
  end

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.REQ && (bus.SELEC == SEL_EXT) && empty_q) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!empty_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs (pop strobe and next write-back value)
  always_comb begin
    pop        = 1'b0;
    dato_d     = dato_q;
    dato_val_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.REQ) begin
          dato_val_d = 1'b1;
          case (bus.SELEC)
            SEL_RY:  dato_d = ry_ext;
            SEL_RYD: dato_d = bus.RY_DATO;
            SEL_EXT: begin
              if (!empty_q) begin
                pop    = 1'b1;
                dato_d = head;
              end else begin
                dato_val_d = 1'b0;
              end
            end
            SEL_IMM: dato_d = bus.IMM;
            default: dato_d = '0;
          endcase
        end
      end
      S_WAIT: begin
        if (!empty_q) begin
          pop        = 1'b1;
          dato_d     = head;
          dato_val_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A pop only happens on a non-empty FIFO, so a full FIFO with a pop
  // always has room for the simultaneous push.
  always_comb begin
    push_ok  = bus.DATO_IN_VAL && (!full_q || pop);
    ovf_set  = bus.DATO_IN_VAL && full_q && !pop;
    cnt_d    = cnt_q + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop};
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    empty_d  = (cnt_d == '0);
    full_d   = (cnt_d == FULL_CNT);
    ovf_d    = ovf_set | (ovf_q & ~bus.OVF_CLR);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      dato_q     <= '0;
      dato_val_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      dato_q     <= dato_d;
      dato_val_q <= dato_val_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_N && push_ok) begin
      mem_q[wr_ptr_q] <= bus.DATO_IN;
    end
  end

  assign bus.DATO      = dato_q;
  assign bus.DATO_VAL  = dato_val_q;
  assign bus.BUSY      = (state_q == S_WAIT);
  assign bus.EXT_EMPTY = empty_q;
  assign bus.EXT_FULL  = full_q;
  assign bus.EXT_OVF   = ovf_q;
  assign bus.STATE_DBG = state_q;

endmodule

// File: doc/mux_wb_reg.md
# mux_wb_reg

Registered write-back source selector for the register file of the 8-bit microcontroller datapath, parametrised in data width and register-index width. It picks the value written into the destination register from the register index, a register operand, an immediate or external input data. External input data is buffered in a small FIFO, so peripheral bytes arriving between instructions are not lost. The result is presented one cycle after a request with a valid pulse, and the block stalls the core when it needs external data that has not arrived yet.

## Interface
Parameters:
- WIDTH, 8, data path width in bits
- REG_BITS, 3, register index width; must satisfy REG_BITS <= WIDTH
- EXT_DEPTH, 4, external input FIFO depth; power of two, >= 2

Ports:
- CLK  in  1  single clock; all state changes on rising edge
- RST_N  in  1  reset, synchronous, active-low
- REQ  in  1  write-back request; sampled when BUSY=0
- SELEC  in  3  source select, sampled with REQ
- RY  in  REG_BITS  register index
- RY_DATO  in  WIDTH  register operand data
- IMM  in  WIDTH  immediate operand
- DATO_IN  in  WIDTH  external input data
- DATO_IN_VAL  in  1  push strobe for DATO_IN into the FIFO
- OVF_CLR  in  1  clears EXT_OVF
- DATO  out  WIDTH  registered write-back data
- DATO_VAL  out  1  one-cycle pulse; DATO is new and must be written
- BUSY  out  1  waiting for external data; core must stall
- EXT_EMPTY  out  1  FIFO empty
- EXT_FULL  out  1  FIFO holds EXT_DEPTH entries
- EXT_OVF  out  1  sticky: a push was dropped because the FIFO was full

## Operation
- Source encoding:
  - 001: {zeros, RY}, zero-extended to WIDTH.
  - 010: RY_DATO.
  - 011: FIFO head; the head is popped.
  - 100: IMM.
  - Any other code: all zeros, still with DATO_VAL.
- FSM states:
  - IDLE (reset state):
    - REQ=1 with SELEC other than 011 → capture the selected source into DATO, pulse DATO_VAL; stay in IDLE.
    - REQ=1, SELEC=011, FIFO non-empty → pop the head into DATO, pulse DATO_VAL; stay in IDLE.
    - REQ=1, SELEC=011, FIFO empty → go to WAIT_EXT, BUSY=1.
  - WAIT_EXT:
    - REQ and SELEC are ignored.
    - On the first cycle the FIFO is non-empty: pop the head into DATO, pulse DATO_VAL, return to IDLE.
- FIFO:
  - DATO_IN_VAL=1 with FIFO not full → push DATO_IN.
  - DATO_IN_VAL=1 with FIFO full → drop the data and set EXT_OVF. The head and count are unchanged.
  - Push and pop in the same cycle on a non-empty FIFO → both happen; count unchanged. On a full FIFO the pop frees the slot, so the push is accepted and EXT_OVF is not set.
  - There is no bypass. A push into an empty FIFO becomes visible to a pop one cycle later.
  - Read and write pointers are log2(EXT_DEPTH) bits wide and wrap modulo EXT_DEPTH. The count is log2(EXT_DEPTH)+1 bits.
- EXT_OVF stays set until OVF_CLR=1 or reset. If OVF_CLR and a new overflow occur in the same cycle, the set wins.
- DATO holds its last value between requests. It changes only in a cycle that produces a DATO_VAL pulse.

## Timing
- Reset (RST_N=0 at a rising edge) forces:
  - DATO=0, DATO_VAL=0, BUSY=0, EXT_OVF=0.
  - FIFO empty: EXT_EMPTY=1, EXT_FULL=0, pointers 0.
  - State IDLE.
  - Reset takes priority over every other input.
- Latency:
  - REQ sampled at edge k (IDLE, data available) → DATO and DATO_VAL=1 after edge k. DATO_VAL drops after edge k+1 unless another REQ is accepted.
  - Back-to-back REQ on consecutive cycles → DATO_VAL high continuously, new DATO every cycle.
- Stall:
  - BUSY rises after the edge that accepts a REQ with SELEC=011 on an empty FIFO.
  - A push at edge m makes the FIFO non-empty after edge m. The pop, DATO_VAL pulse and BUSY=0 all follow edge m+1.
- Reset mid-operation: reset in WAIT_EXT aborts the pending request. No DATO_VAL is issued and any pending push is discarded.
- Flags are registered and reflect the state after the last edge:
  - EXT_FULL is high when the count equals EXT_DEPTH.
  - EXT_EMPTY is high when the count is 0.

## Test plan
- Reset, then REQ with SELEC=001, RY=3'b101 → DATO=8'h05, single DATO_VAL pulse one cycle later. Then SELEC=010, RY_DATO=8'hA7 → DATO=8'hA7. Then SELEC=100, IMM=8'h3C → DATO=8'h3C. Then SELEC=111 → DATO=8'h00 with DATO_VAL.
- Push 8'h11, 8'h22, then two REQs with SELEC=011 → DATO=8'h11 then 8'h22. EXT_EMPTY=1 after the second pop.
- REQ with SELEC=011 on an empty FIFO → BUSY=1 for 3 idle cycles. Push 8'h9E → the pop follows the next edge: DATO=8'h9E, DATO_VAL pulse, BUSY=0 in the same cycle.
- Push 5 bytes (8'h01..8'h05) with EXT_DEPTH=4 → EXT_FULL=1 and EXT_OVF=1. Four pops return 8'h01..8'h04. OVF_CLR then clears EXT_OVF.
- With a full FIFO, push and pop in the same cycle → count stays 4, EXT_OVF stays 0. Continue push+pop for 10 cycles → pointers wrap and the data order is preserved.
- Assert RST_N=0 during WAIT_EXT while pushing → no DATO_VAL, BUSY=0, DATO=0, EXT_EMPTY=1 after the edge.
